ppu_update_ctrl: RTL and testbench
==================================

PPU_UPDATE_CTRL -- requirements
Module: ppu_update_ctrl

Interface
REQ-001 Parameter UPD_CYCLES, default 2: number of clock cycles update is held high per commit (legal range 1..15).
REQ-002 clock  input  1  single system clock; all logic on its rising edge.
REQ-003 reset  input  1  synchronous, active-low reset.
REQ-004 wr_req  input  1  game FSM requests one table write.
REQ-005 wr_kind  input  2  write target: 0 sprite, 1 static, 2 offset, 3 reserved.
REQ-006 wr_index  input  3  entry number for sprite or static writes, 0..5.
REQ-007 wr_data  input  30  entry payload: sprite [29:0]; static [21:0]; offset x = [11:0] and y = [23:12].
REQ-008 wr_ack  output  1  one-cycle pulse: write taken.
REQ-009 wr_err  output  1  one-cycle pulse with wr_ack when the write was discarded.
REQ-010 commit_req  input  1  one-cycle pulse: frame data complete, publish it at the next blank.
REQ-011 vblank  input  1  high during vertical blanking.
REQ-012 update  output  1  tells the PPU to latch the published tables.
REQ-013 sprites  output  180  published sprite table, entry i at [30i+29:30i].
REQ-014 statics  output  132  published static table, entry i at [22i+21:22i].
REQ-015 offset_x, offset_y  output  12 each  published viewport offset.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 overrun  output  1  sticky flag: commit_req arrived while busy.
REQ-018 frame_cnt  output  8  count of completed commits.

Function
REQ-019 Storage: shadow tables of 6x30-bit sprite entries, 6x22-bit static entries and 2x12-bit offsets, plus published copies of the same size that drive the outputs directly.
REQ-020 FSM states are IDLE, WAIT_VB, COMMIT and HOLD, and there are no other states.
REQ-021 Write acceptance happens in IDLE only: when wr_req=1 and wr_ack=0, the shadow entry is written at the clock edge and wr_ack=1 on the next cycle.
REQ-022 Write pacing: wr_ack is never high on two consecutive cycles; a requester that holds wr_req gets one write every 2 cycles; the requester must drop wr_req on seeing wr_ack.
REQ-023 Discarded writes: wr_kind=3, or wr_index of 6 or 7 for sprite/static writes, leaves all shadow storage unchanged and gives wr_ack=1 with wr_err=1.
REQ-024 Static writes store wr_data[21:0]; offset writes store the x and y fields; unused wr_data bits are ignored.
REQ-025 Outside IDLE, wr_req is not acknowledged; it stays pending and is accepted after the return to IDLE.
REQ-026 IDLE -> WAIT_VB on commit_req=1; if wr_req and commit_req are both sampled in IDLE on the same cycle, the write is accepted first and is part of this commit.
REQ-027 vblank is registered once; a rising edge means registered vblank was 0 and the current vblank is 1.
REQ-028 WAIT_VB -> COMMIT on a vblank rising edge only; if vblank is already high when WAIT_VB is entered, the block waits for the next rising edge.
REQ-029 COMMIT lasts 1 cycle: all shadow storage is copied to the published copies, and update is 1 from the next cycle.
REQ-030 HOLD: update stays 1 for UPD_CYCLES cycles, counted by a 4-bit counter; then update=0, frame_cnt increments (255 wraps to 0), and the FSM returns to IDLE.
REQ-031 The published outputs change only in COMMIT and are stable at every other time.
REQ-032 commit_req while busy=1 is ignored, and overrun is set to 1 and stays 1 until reset.
REQ-033 If vblank falls during HOLD, the commit still completes normally.

Reset
REQ-034 With reset=0 at a clock edge: FSM goes to IDLE; shadow and published storage go to 0; update, wr_ack, wr_err, overrun and busy go to 0; frame_cnt goes to 0.
REQ-035 Reset mid-operation, in any state, aborts the commit, and the cycle after release is IDLE with all outputs 0.

Verification
REQ-036 Write sprite index 1 with data 0x2AAAAAAA, commit, then pulse vblank -> sprites[59:30]=0x2AAAAAAA, update high for exactly 2 cycles, frame_cnt=1.
REQ-037 Hold wr_req for 6 cycles with index 0..5 static data -> 3 acks, one every 2 cycles, no wr_err.
REQ-038 wr_kind=0 with wr_index=7 -> wr_ack=1 and wr_err=1, sprites unchanged after commit.
REQ-039 commit_req while vblank=1 -> no update until vblank falls and rises again; a second commit_req during WAIT_VB -> overrun=1.
REQ-040 Write offset wr_data=0x0123456 while in WAIT_VB -> no ack; ack follows the return to IDLE; offset_x=0x456 and offset_y=0x123 only after the next commit.
REQ-041 Assert reset=0 during HOLD -> next cycle update=0, outputs 0, frame_cnt=0, and 256 commits -> frame_cnt wraps to 0.

Source files
------------

// File: rtl/ppu_update_if.sv
// Write/commit handshake between the game FSM (master) and the PPU update controller (slave).
interface ppu_update_if;
    logic        wr_req;
    logic [1:0]  wr_kind;
    logic [2:0]  wr_index;
    logic [29:0] wr_data;
    logic        wr_ack;
    logic        wr_err;
    logic        commit_req;

    modport master (
        output wr_req, wr_kind, wr_index, wr_data, commit_req,
        input  wr_ack, wr_err
    );

    modport slave (
        input  wr_req, wr_kind, wr_index, wr_data, commit_req,
        output wr_ack, wr_err
    );
endinterface

// File: rtl/ppu_update_ctrl.sv
// Double-buffered PPU table controller: shadow writes in IDLE, publish on the next vblank
// rising edge, then hold update high for UPD_CYCLES cycles.
module ppu_update_ctrl #(
    parameter int unsigned UPD_CYCLES = 2
) (
    input  logic          clock,
    input  logic          reset,
    ppu_update_if.slave   wr_bus,
    input  logic          vblank,
    output logic          update,
    output logic [179:0]  sprites,
    output logic [131:0]  statics,
    output logic [11:0]   offset_x,
    output logic [11:0]   offset_y,
    output logic          busy,
    output logic          overrun,
    output logic [7:0]    frame_cnt
);

    typedef enum logic [1:0] {StIdle, StWaitVb, StCommit, StHold} state_e;

    state_e      state_q, state_d;
    logic [3:0]  hold_cnt_q, hold_cnt_d;
    logic        ack_q, ack_d;
    logic        err_q, err_d;
    logic        vblank_q;
    logic        overrun_q, overrun_d;
    logic [7:0]  frame_q, frame_d;

    logic [29:0] sh_spr_q [6];
    logic [29:0] sh_spr_d [6];
    logic [21:0] sh_sta_q [6];
    logic [21:0] sh_sta_d [6];
    logic [11:0] sh_ox_q, sh_ox_d, sh_oy_q, sh_oy_d;

    logic [29:0] pub_spr_q [6];
    logic [29:0] pub_spr_d [6];
    logic [21:0] pub_sta_q [6];
    logic [21:0] pub_sta_d [6];
    logic [11:0] pub_ox_q, pub_ox_d, pub_oy_q, pub_oy_d;

    logic wr_take;
    logic idx_ok;
    logic vb_rise;

    assign wr_take = (state_q == StIdle) && wr_bus.wr_req && !ack_q;
    assign idx_ok  = wr_bus.wr_index < 3'd6;
    assign vb_rise = !vblank_q && vblank;

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        ack_d      = 1'b0;
        err_d      = 1'b0;
        overrun_d  = overrun_q;
        frame_d    = frame_q;
        sh_spr_d   = sh_spr_q;
        sh_sta_d   = sh_sta_q;
        sh_ox_d    = sh_ox_q;
        sh_oy_d    = sh_oy_q;
        pub_spr_d  = pub_spr_q;
        pub_sta_d  = pub_sta_q;
        pub_ox_d   = pub_ox_q;
        pub_oy_d   = pub_oy_q;

        if (wr_take) begin
            ack_d = 1'b1;
            unique case (wr_bus.wr_kind)
                2'd0: begin
                    err_d = !idx_ok;
                    for (int i = 0; i < 6; i++) begin
                        if (wr_bus.wr_index == 3'(i)) sh_spr_d[i] = wr_bus.wr_data;
                    end
                end
                2'd1: begin
                    err_d = !idx_ok;
                    for (int i = 0; i < 6; i++) begin
                        if (wr_bus.wr_index == 3'(i)) sh_sta_d[i] = wr_bus.wr_data[21:0];
                    end
                end
                2'd2: begin
                    sh_ox_d = wr_bus.wr_data[11:0];
                    sh_oy_d = wr_bus.wr_data[23:12];
                end
                default: err_d = 1'b1;
            endcase
        end

        if (wr_bus.commit_req && (state_q != StIdle)) overrun_d = 1'b1;

        case (state_q)
            StIdle: begin
                if (wr_bus.commit_req) state_d = StWaitVb;
            end
            StWaitVb: begin
                if (vb_rise) state_d = StCommit;
            end
            StCommit: begin
                pub_spr_d  = sh_spr_q;
                pub_sta_d  = sh_sta_q;
                pub_ox_d   = sh_ox_q;
                pub_oy_d   = sh_oy_q;
                hold_cnt_d = 4'd0;
                state_d    = StHold;
            end
            StHold: begin
                if (hold_cnt_q == 4'(UPD_CYCLES - 1)) begin
                    frame_d = frame_q + 8'd1;
                    state_d = StIdle;
                end else begin
                    hold_cnt_d = hold_cnt_q + 4'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= StIdle;
            hold_cnt_q <= 4'd0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            vblank_q   <= 1'b0;
            overrun_q  <= 1'b0;
            frame_q    <= 8'd0;
            sh_ox_q    <= 12'd0;
            sh_oy_q    <= 12'd0;
            pub_ox_q   <= 12'd0;
            pub_oy_q   <= 12'd0;
            for (int i = 0; i < 6; i++) begin
                sh_spr_q[i]  <= 30'd0;
                sh_sta_q[i]  <= 22'd0;
                pub_spr_q[i] <= 30'd0;
                pub_sta_q[i] <= 22'd0;
            end
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            vblank_q   <= vblank;
            overrun_q  <= overrun_d;
            frame_q    <= frame_d;
            sh_ox_q    <= sh_ox_d;
            sh_oy_q    <= sh_oy_d;
            pub_ox_q   <= pub_ox_d;
            pub_oy_q   <= pub_oy_d;
            sh_spr_q   <= sh_spr_d;
            sh_sta_q   <= sh_sta_d;
            pub_spr_q  <= pub_spr_d;
            pub_sta_q  <= pub_sta_d;
        end
    end

    always_comb begin
        sprites = '0;
        statics = '0;
        for (int i = 0; i < 6; i++) begin
            sprites[30*i +: 30] = pub_spr_q[i];
            statics[22*i +: 22] = pub_sta_q[i];
        end
    end

    assign offset_x      = pub_ox_q;
    assign offset_y      = pub_oy_q;
    assign update        = (state_q == StHold);
    assign busy          = (state_q != StIdle);
    assign overrun       = overrun_q;
    assign frame_cnt     = frame_q;
    assign wr_bus.wr_ack = ack_q;
    assign wr_bus.wr_err = err_q;

endmodule

// File: tb/tb_ppu_update_ctrl.sv
// Directed bench for ppu_update_ctrl with UPD_CYCLES = 2.
module tb_ppu_update_ctrl;

    logic         clock;
    logic         reset;
    logic         vblank;
    logic         update;
    logic [179:0] sprites;
    logic [131:0] statics;
    logic [11:0]  offset_x;
    logic [11:0]  offset_y;
    logic         busy;
    logic         overrun;
    logic [7:0]   frame_cnt;

    int checks = 0;
    int errors = 0;
    int exp_frames = 0;
    int ack_cnt;
    int err_cnt;

    ppu_update_if bus ();

    ppu_update_ctrl #(.UPD_CYCLES(2)) dut (
        .clock     (clock),
        .reset     (reset),
        .wr_bus    (bus.slave),
        .vblank    (vblank),
        .update    (update),
        .sprites   (sprites),
        .statics   (statics),
        .offset_x  (offset_x),
        .offset_y  (offset_y),
        .busy      (busy),
        .overrun   (overrun),
        .frame_cnt (frame_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Full commit cycle; waits (bounded) for the controller to return to IDLE.
    task automatic do_commit();
        int n;
        bus.commit_req = 1'b1;
        step();
        bus.commit_req = 1'b0;
        vblank = 1'b0;
        step();
        vblank = 1'b1;
        step();
        n = 0;
        while (busy && n < 20) begin
            step();
            n++;
        end
        vblank = 1'b0;
        exp_frames = (exp_frames + 1) % 256;
        chk("commit_done", {31'd0, busy}, 32'd0);
    endtask

    task automatic write(input logic [1:0] kind, input logic [2:0] idx, input logic [29:0] data);
        bus.wr_req   = 1'b1;
        bus.wr_kind  = kind;
        bus.wr_index = idx;
        bus.wr_data  = data;
        step();
        bus.wr_req = 1'b0;
    endtask

    initial begin
        reset          = 1'b0;
        vblank         = 1'b0;
        bus.wr_req     = 1'b0;
        bus.wr_kind    = 2'd0;
        bus.wr_index   = 3'd0;
        bus.wr_data    = 30'd0;
        bus.commit_req = 1'b0;
        step();
        step();
        chk("rst_update", {31'd0, update}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_ack", {31'd0, bus.wr_ack}, 32'd0);
        chk("rst_frame", {24'd0, frame_cnt}, 32'd0);
        chk("rst_spr1", {2'd0, sprites[59:30]}, 32'd0);
        reset = 1'b1;
        step();

        // Sprite write + single commit with cycle-accurate update window
        write(2'd0, 3'd1, 30'h2AAAAAAA);
        chk("t1_ack", {31'd0, bus.wr_ack}, 32'd1);
        chk("t1_err", {31'd0, bus.wr_err}, 32'd0);
        bus.commit_req = 1'b1;
        step();
        bus.commit_req = 1'b0;
        chk("t1_busy", {31'd0, busy}, 32'd1);
        chk("t1_spr_pre", {2'd0, sprites[59:30]}, 32'd0);
        vblank = 1'b1;
        step();
        chk("t1_commit_upd", {31'd0, update}, 32'd0);
        step();
        chk("t1_upd1", {31'd0, update}, 32'd1);
        chk("t1_spr", {2'd0, sprites[59:30]}, 32'h2AAAAAAA);
        step();
        chk("t1_upd2", {31'd0, update}, 32'd1);
        step();
        chk("t1_upd_end", {31'd0, update}, 32'd0);
        chk("t1_frame", {24'd0, frame_cnt}, 32'd1);
        chk("t1_idle", {31'd0, busy}, 32'd0);
        exp_frames = 1;
        vblank = 1'b0;
        step();

        // Held wr_req: one ack every other cycle, indices 0, 2, 4 taken
        ack_cnt = 0;
        err_cnt = 0;
        bus.wr_req  = 1'b1;
        bus.wr_kind = 2'd1;
        for (int i = 0; i < 6; i++) begin
            bus.wr_index = 3'(i);
            bus.wr_data  = 30'h3FC00000 | (30'h100000 + 30'(i));
            step();
            chk("t2_ack_seq", {31'd0, bus.wr_ack}, (i % 2 == 0) ? 32'd1 : 32'd0);
            ack_cnt += int'(bus.wr_ack);
            err_cnt += int'(bus.wr_err);
        end
        bus.wr_req = 1'b0;
        chk("t2_acks", ack_cnt, 32'd3);
        chk("t2_errs", err_cnt, 32'd0);
        do_commit();
        chk("t2_sta0", {10'd0, statics[21:0]}, 32'h100000);
        chk("t2_sta1", {10'd0, statics[43:22]}, 32'd0);
        chk("t2_sta2", {10'd0, statics[65:44]}, 32'h100002);
        chk("t2_sta4", {10'd0, statics[109:88]}, 32'h100004);

        // Discarded writes
        write(2'd0, 3'd7, 30'h1234567);
        chk("t3_ack", {31'd0, bus.wr_ack}, 32'd1);
        chk("t3_err", {31'd0, bus.wr_err}, 32'd1);
        step();
        write(2'd3, 3'd0, 30'h3FFFFFFF);
        chk("t3_err_k3", {31'd0, bus.wr_err}, 32'd1);
        step();
        do_commit();
        chk("t3_spr0", {2'd0, sprites[29:0]}, 32'd0);
        chk("t3_spr1", {2'd0, sprites[59:30]}, 32'h2AAAAAAA);
        chk("t3_ox", {20'd0, offset_x}, 32'd0);
        chk("t3_frame", {24'd0, frame_cnt}, exp_frames);

        // Commit with vblank already high; overrun; pending offset write
        vblank = 1'b1;
        step();
        bus.commit_req = 1'b1;
        step();
        bus.commit_req = 1'b0;
        step();
        step();
        chk("t4_no_upd", {31'd0, update}, 32'd0);
        chk("t4_busy", {31'd0, busy}, 32'd1);
        chk("t4_no_ovr", {31'd0, overrun}, 32'd0);
        bus.commit_req = 1'b1;
        step();
        bus.commit_req = 1'b0;
        chk("t4_overrun", {31'd0, overrun}, 32'd1);
        bus.wr_req  = 1'b1;
        bus.wr_kind = 2'd2;
        bus.wr_data = 30'h0123456;
        step();
        chk("t4_wv_noack", {31'd0, bus.wr_ack}, 32'd0);
        vblank = 1'b0;
        step();
        chk("t4_wv_noack2", {31'd0, bus.wr_ack}, 32'd0);
        vblank = 1'b1;
        step();
        chk("t4_commit_noack", {31'd0, bus.wr_ack}, 32'd0);
        step();
        chk("t4_upd", {31'd0, update}, 32'd1);
        chk("t4_ox_hold", {20'd0, offset_x}, 32'd0);
        step();
        step();
        exp_frames++;
        chk("t4_idle", {31'd0, busy}, 32'd0);
        chk("t4_frame", {24'd0, frame_cnt}, exp_frames);
        step();
        chk("t4_late_ack", {31'd0, bus.wr_ack}, 32'd1);
        chk("t4_late_err", {31'd0, bus.wr_err}, 32'd0);
        bus.wr_req = 1'b0;
        chk("t4_ox_pre", {20'd0, offset_x}, 32'd0);
        vblank = 1'b0;
        step();
        do_commit();
        chk("t4_ox", {20'd0, offset_x}, 32'h456);
        chk("t4_oy", {20'd0, offset_y}, 32'h123);
        chk("t4_ovr_sticky", {31'd0, overrun}, 32'd1);

        // Reset during HOLD
        bus.commit_req = 1'b1;
        step();
        bus.commit_req = 1'b0;
        vblank = 1'b0;
        step();
        vblank = 1'b1;
        step();
        step();
        chk("t5_in_hold", {31'd0, update}, 32'd1);
        reset = 1'b0;
        step();
        reset = 1'b1;
        vblank = 1'b0;
        chk("t5_upd", {31'd0, update}, 32'd0);
        chk("t5_busy", {31'd0, busy}, 32'd0);
        chk("t5_frame", {24'd0, frame_cnt}, 32'd0);
        chk("t5_ovr", {31'd0, overrun}, 32'd0);
        chk("t5_spr1", {2'd0, sprites[59:30]}, 32'd0);
        chk("t5_ox", {20'd0, offset_x}, 32'd0);
        step();
        chk("t5_post_busy", {31'd0, busy}, 32'd0);
        exp_frames = 0;

        // Frame counter wrap
        for (int i = 0; i < 255; i++) do_commit();
        chk("t6_frame255", {24'd0, frame_cnt}, 32'd255);
        do_commit();
        chk("t6_wrap", {24'd0, frame_cnt}, 32'd0);
        chk("t6_model", {24'd0, frame_cnt}, exp_frames);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
